// File: rtl/wb_ram_bank_ctrl_pkg.sv
// rtl/wb_ram_bank_ctrl_pkg.sv - Wishbone cycle/burst codes and controller types
package wb_ram_bank_ctrl_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INC     = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    localparam int BANK_ADDR_W = 15;

    // A single bank still needs one index bit so the range check can reject bank 1.
    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/wb_burst_next_addr.sv
// rtl/wb_burst_next_addr.sv - next Wishbone burst byte address for linear and wrap bursts
module wb_burst_next_addr
    import wb_ram_bank_ctrl_pkg::*;
(
    input  logic [31:0] adr,
    input  logic [1:0]  bte,
    output logic [31:0] next_adr
);

    logic [31:0] inc_adr;

    assign inc_adr = adr + 32'd4;

    // Wrap bursts only advance the low word bits; everything above is held.
    always_comb begin
        next_adr = inc_adr;
        case (bte)
            BTE_LINEAR: next_adr = inc_adr;
            BTE_WRAP4:  next_adr = {adr[31:4], inc_adr[3:2], adr[1:0]};
            BTE_WRAP8:  next_adr = {adr[31:5], inc_adr[4:2], adr[1:0]};
            BTE_WRAP16: next_adr = {adr[31:6], inc_adr[5:2], adr[1:0]};
            default:    next_adr = inc_adr;
        endcase
    end

endmodule

// File: rtl/wb_ram_bank_ctrl.sv
// rtl/wb_ram_bank_ctrl.sv - Wishbone B3 slave front-end steering reads/writes into BRAM banks
module wb_ram_bank_ctrl
    import wb_ram_bank_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [2:0]                wb_cti_i,
    input  logic [1:0]                wb_bte_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [3:0]                bank_we,
    output logic [31:0]               bank_din,
    output logic [BANK_ADDR_W-1:0]    bank_waddr,
    output logic [BANK_ADDR_W-1:0]    bank_raddr,
    output logic [NUM_BANKS-1:0]      bank_select,
    input  logic [32*NUM_BANKS-1:0]   bank_dout
);

    localparam int BW = bank_idx_w(NUM_BANKS);

    state_e             state_q, state_d;
    logic [BW-1:0]      rd_bank_q, rd_bank_d;
    logic [31:0]        next_adr;
    logic [BW-1:0]      cur_bank, nxt_bank, issue_bank;
    logic [BANK_AW-1:0] raddr;
    logic               req, cur_ok, nxt_ok, burst_cont, wr_beat, rd_issue;
    logic               unused_ok;

    wb_burst_next_addr u_next_addr (
        .adr      (wb_adr_i),
        .bte      (wb_bte_i),
        .next_adr (next_adr)
    );

    assign req        = wb_cyc_i & wb_stb_i;
    assign cur_bank   = wb_adr_i[BANK_AW+2 +: BW];
    assign nxt_bank   = next_adr[BANK_AW+2 +: BW];
    assign cur_ok     = (32'(cur_bank) < NUM_BANKS);
    assign nxt_ok     = (32'(nxt_bank) < NUM_BANKS);
    assign burst_cont = (state_q == ST_ACK) & req & (wb_cti_i == CTI_INC);
    assign wr_beat    = (state_q == ST_ACK) & req & wb_we_i;
    assign unused_ok  = ^{wb_adr_i, next_adr};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = cur_ok ? ST_ACK : ST_ERR;
            ST_ACK:  state_d = burst_cont ? (nxt_ok ? ST_ACK : ST_ERR) : ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The read for the next beat is launched while the current one is acked,
    // so the synchronous BRAM output lines up with the following ack.
    always_comb begin
        rd_issue   = 1'b0;
        issue_bank = cur_bank;
        raddr      = wb_adr_i[BANK_AW+1:2];
        if (state_q == ST_IDLE) begin
            rd_issue = req & cur_ok;
        end else if (burst_cont) begin
            rd_issue   = nxt_ok;
            issue_bank = nxt_bank;
            raddr      = next_adr[BANK_AW+1:2];
        end
        rd_bank_d = rd_issue ? issue_bank : rd_bank_q;
    end

    always_comb begin
        bank_select = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (wr_beat) begin
                bank_select[k] = (cur_bank == BW'(k));
            end else if (rd_issue) begin
                bank_select[k] = (issue_bank == BW'(k));
            end
        end
    end

    always_comb begin
        wb_dat_o = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (rd_bank_q == BW'(k)) wb_dat_o = bank_dout[32*k +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_bank_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Ack is qualified by the strobe so a master wait state mid-burst drops it.
    assign wb_ack_o   = (state_q == ST_ACK) & req;
    assign wb_err_o   = (state_q == ST_ERR);
    assign bank_we    = wb_sel_i & {4{wr_beat}};
    assign bank_din   = wb_dat_i;
    assign bank_waddr = BANK_ADDR_W'(wb_adr_i[BANK_AW+1:2]);
    assign bank_raddr = BANK_ADDR_W'(raddr);

endmodule
